// File: rtl/seg7_scan_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_if
//   Bundles the load/enable side and the display-pin side of the seven-segment
//   scan driver.
//   Signals (named from the driver's point of view):
//     i_en          display enable (0 blanks outputs, scanning continues)
//     i_load        one-cycle strobe capturing i_data / i_mask
//     i_data[31:0]  eight hex digits, digit k = i_data[4k+3:4k]
//     i_mask[7:0]   per-digit enable, 0 blanks that digit
//     o_an[7:0]     active-low one-hot digit select
//     o_seg[6:0]    active-low segments {g,f,e,d,c,b,a}
//     o_frame_done  one-cycle pulse after the scan wraps 7 -> 0
//   Modports: master = producer of data / consumer of pins, slave = driver.
// -----------------------------------------------------------------------------
interface seg7_scan_if;
   logic        i_en;
   logic        i_load;
   logic [31:0] i_data;
   logic [7:0]  i_mask;
   logic [7:0]  o_an;
   logic [6:0]  o_seg;
   logic        o_frame_done;

   modport master (
      output i_en, i_load, i_data, i_mask,
      input  o_an, o_seg, o_frame_done
   );

   modport slave (
      input  i_en, i_load, i_data, i_mask,
      output o_an, o_seg, o_frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for an 8-digit common-anode seven-segment display.
//   A prescaler advances a 3-bit scan index every DIV cycles; each digit gets
//   an active-low one-hot anode select and an active-low hex segment pattern.
//   Loads are staged in pending registers and only committed at the 7 -> 0
//   frame boundary, so a displayed frame is never a mix of old and new data.
//   Ports:
//     i_clk    system clock, rising edge
//     i_rst    synchronous active-high reset
//     io_scan  seg7_scan_if.slave (en/load/data/mask in, an/seg/frame_done out)
//   Parameter:
//     DIV      cycles each digit stays lit, 2 .. 2^20
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int DIV = 50000
) (
   input  logic           i_clk,
   input  logic           i_rst,
   seg7_scan_if.slave     io_scan
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   // Active-low hex decode, segment order {g,f,e,d,c,b,a}
   function automatic logic [6:0] f_hex7(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         4'hF:    seg = 7'b0001110;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [31:0]   r_act_data;
   logic [7:0]    r_act_mask;
   logic [31:0]   r_pend_data;
   logic [7:0]    r_pend_mask;
   logic          r_pending;
   logic          r_frame_done;
   logic [7:0]    r_an;
   logic [6:0]    r_seg;

   logic          w_tick;
   logic          w_wrap;
   logic [3:0]    w_digit;
   logic [7:0]    w_an_nxt;
   logic [6:0]    w_seg_nxt;

   assign w_tick = (r_cnt == CW'(DIV - 1));
   assign w_wrap = w_tick && (r_idx == 3'd7);

   // Next-cycle pin values from the current scan index, active data and enable
   always_comb begin
      w_digit   = r_act_data[{r_idx, 2'b00} +: 4];
      w_an_nxt  = 8'hFF;
      w_seg_nxt = 7'h7F;
      if (io_scan.i_en && r_act_mask[r_idx]) begin
         w_an_nxt  = ~(8'b1 << r_idx);
         w_seg_nxt = f_hex7(w_digit);
      end else begin
         w_an_nxt  = 8'hFF;
         w_seg_nxt = 7'h7F;
      end
   end

   // Prescaler and scan index; the index wraps naturally at 3 bits
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_idx <= 3'd0;
      end else if (w_tick) begin
         r_cnt <= '0;
         r_idx <= r_idx + 3'd1;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Staging of loads; a load landing on the wrap cycle bypasses pending
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_act_data  <= 32'h0;
         r_act_mask  <= 8'h00;
         r_pend_data <= 32'h0;
         r_pend_mask <= 8'h00;
         r_pending   <= 1'b0;
      end else if (w_wrap) begin
         if (io_scan.i_load) begin
            r_act_data <= io_scan.i_data;
            r_act_mask <= io_scan.i_mask;
         end else if (r_pending) begin
            r_act_data <= r_pend_data;
            r_act_mask <= r_pend_mask;
         end
         r_pending <= 1'b0;
      end else if (io_scan.i_load) begin
         r_pend_data <= io_scan.i_data;
         r_pend_mask <= io_scan.i_mask;
         r_pending   <= 1'b1;
      end
   end

   // Registered pins and frame pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_an         <= 8'hFF;
         r_seg        <= 7'h7F;
         r_frame_done <= 1'b0;
      end else begin
         r_an         <= w_an_nxt;
         r_seg        <= w_seg_nxt;
         r_frame_done <= w_wrap;
      end
   end

   assign io_scan.o_an         = r_an;
   assign io_scan.o_seg        = r_seg;
   assign io_scan.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with DIV=4 (one frame = 32 cycles).
//   "cyc" counts rising edges since the last reset release; after edge cyc the
//   pins show the digit ((cyc-1)/4)%8 and frame_done is high when cyc%32==0.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

   localparam int DIV = 4;

   logic clk;
   logic rst;
   int   cyc;
   int   errors;
   int   checks;

   seg7_scan_if bus ();

   seg7_scan_driver #(.DIV(DIV)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .io_scan (bus)
   );

   always #5 clk = ~clk;

   // Segment table transcribed from the display datasheet ordering {g..a}
   function automatic logic [6:0] hex7(input int nib);
      case (nib)
         0:  return 7'b1000000;
         1:  return 7'b1111001;
         2:  return 7'b0100100;
         3:  return 7'b0110000;
         4:  return 7'b0011001;
         5:  return 7'b0010010;
         6:  return 7'b0000010;
         7:  return 7'b1111000;
         8:  return 7'b0000000;
         9:  return 7'b0010000;
         10: return 7'b0001000;
         11: return 7'b0000011;
         12: return 7'b1000110;
         13: return 7'b0100001;
         14: return 7'b0000110;
         15: return 7'b0001110;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      // load during reset must be ignored
      rst = 1'b1;
      bus.i_en = 1'b1;
      bus.i_load = 1'b1;
      bus.i_data = 32'h12345678;
      bus.i_mask = 8'hFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if ({bus.o_an, bus.o_seg, bus.o_frame_done} !== {8'hFF, 7'h7F, 1'b0}) begin
         errors++;
         $display("FAIL reset_state an=%h seg=%b fd=%b exp FF/1111111/0",
                  bus.o_an, bus.o_seg, bus.o_frame_done);
      end
      rst = 1'b0;
      bus.i_load = 1'b0;
      cyc = 0;
      for (int n = 0; n < 32; n++) begin
         step();
         checks++;
         if ({bus.o_an, bus.o_seg} !== {8'hFF, 7'h7F}) begin
            errors++;
            $display("FAIL reset_blank cyc=%0d an=%h seg=%b exp FF/1111111", cyc, bus.o_an, bus.o_seg);
         end
         checks++;
         if (bus.o_frame_done !== (cyc == 32)) begin
            errors++;
            $display("FAIL reset_fd cyc=%0d fd=%b exp %b", cyc, bus.o_frame_done, (cyc == 32));
         end
      end
   endtask

   task automatic test_basic();
      logic [31:0] dat;
      int          d;
      int          n;
      logic        seen;
      dat = 32'h76543210;
      bus.i_load = 1'b1;
      bus.i_data = dat;
      bus.i_mask = 8'hFF;
      step();
      bus.i_load = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 40) begin
         step();
         n++;
         seen = bus.o_frame_done;
      end
      checks++;
      if (!seen || cyc != 64) begin
         errors++;
         $display("FAIL basic_wait_fd seen=%b cyc=%0d exp seen=1 cyc=64", seen, cyc);
      end
      for (int k = 0; k < 32; k++) begin
         step();
         d = ((cyc - 1) / 4) % 8;
         checks++;
         if ({bus.o_an, bus.o_seg} !== {~(8'b1 << d), hex7((dat >> (4 * d)) & 15)}) begin
            errors++;
            $display("FAIL basic_digit cyc=%0d an=%h seg=%b exp %h/%b", cyc, bus.o_an, bus.o_seg,
                     ~(8'b1 << d), hex7((dat >> (4 * d)) & 15));
         end
      end
   endtask

   task automatic test_tear_free();
      int d;
      // cyc == 96 here, display shows 76543210
      bus.i_load = 1'b1;
      bus.i_data = 32'h11111111;
      step();
      bus.i_load = 1'b0;
      step();
      bus.i_load = 1'b1;
      bus.i_data = 32'h22222222;
      step();
      bus.i_load = 1'b0;
      while (cyc < 128) begin
         step();
         d = ((cyc - 1) / 4) % 8;
         checks++;
         if ({bus.o_an, bus.o_seg} !== {~(8'b1 << d), hex7(d)}) begin
            errors++;
            $display("FAIL tear_old cyc=%0d an=%h seg=%b exp %h/%b", cyc, bus.o_an, bus.o_seg,
                     ~(8'b1 << d), hex7(d));
         end
      end
      while (cyc < 160) begin
         step();
         d = ((cyc - 1) / 4) % 8;
         checks++;
         if ({bus.o_an, bus.o_seg} !== {~(8'b1 << d), 7'b0100100}) begin
            errors++;
            $display("FAIL tear_new cyc=%0d an=%h seg=%b exp %h/0100100", cyc, bus.o_an, bus.o_seg,
                     ~(8'b1 << d));
         end
      end
   endtask

   task automatic test_load_on_wrap();
      logic [31:0] dat;
      int          d;
      dat = 32'hFEDCBA98;
      // after edge 191 the driver sits at idx 7, cnt 3: the wrap cycle
      while (cyc < 191) step();
      bus.i_load = 1'b1;
      bus.i_data = dat;
      bus.i_mask = 8'hFF;
      step();
      bus.i_load = 1'b0;
      checks++;
      if ({bus.o_frame_done, bus.o_an, bus.o_seg} !== {1'b1, 8'h7F, 7'b0100100}) begin
         errors++;
         $display("FAIL wrap_edge cyc=%0d fd=%b an=%h seg=%b exp 1/7F/0100100",
                  cyc, bus.o_frame_done, bus.o_an, bus.o_seg);
      end
      while (cyc < 224) begin
         step();
         d = ((cyc - 1) / 4) % 8;
         checks++;
         if ({bus.o_an, bus.o_seg} !== {~(8'b1 << d), hex7((dat >> (4 * d)) & 15)}) begin
            errors++;
            $display("FAIL wrap_digit cyc=%0d an=%h seg=%b exp %h/%b", cyc, bus.o_an, bus.o_seg,
                     ~(8'b1 << d), hex7((dat >> (4 * d)) & 15));
         end
      end
   endtask

   task automatic test_mask_enable();
      logic [31:0] dat;
      logic [7:0]  msk;
      logic        en_exp;
      int          d;
      dat = 32'hFEDCBA98;
      msk = 8'b10101010;
      bus.i_load = 1'b1;
      bus.i_data = dat;
      bus.i_mask = msk;
      step();
      bus.i_load = 1'b0;
      while (cyc < 256) step();
      while (cyc < 320) begin
         // en low is sampled on edges 293..297
         bus.i_en = (cyc >= 292 && cyc < 297) ? 1'b0 : 1'b1;
         step();
         en_exp = !(cyc >= 293 && cyc <= 297);
         d = ((cyc - 1) / 4) % 8;
         checks++;
         if (en_exp && msk[d]) begin
            if ({bus.o_an, bus.o_seg} !== {~(8'b1 << d), hex7((dat >> (4 * d)) & 15)}) begin
               errors++;
               $display("FAIL mask_lit cyc=%0d an=%h seg=%b exp %h/%b", cyc, bus.o_an, bus.o_seg,
                        ~(8'b1 << d), hex7((dat >> (4 * d)) & 15));
            end
         end else begin
            if ({bus.o_an, bus.o_seg} !== {8'hFF, 7'h7F}) begin
               errors++;
               $display("FAIL mask_blank cyc=%0d an=%h seg=%b exp FF/1111111", cyc, bus.o_an, bus.o_seg);
            end
         end
         checks++;
         if (bus.o_frame_done !== (cyc % 32 == 0)) begin
            errors++;
            $display("FAIL mask_fd cyc=%0d fd=%b exp %b", cyc, bus.o_frame_done, (cyc % 32 == 0));
         end
      end
   endtask

   task automatic test_reset_mid();
      // pending load, then reset while digit 3 is lit
      bus.i_load = 1'b1;
      bus.i_data = 32'h33333333;
      bus.i_mask = 8'hFF;
      while (cyc < 330) step();
      step();
      bus.i_load = 1'b0;
      while (cyc < 334) step();
      checks++;
      if (bus.o_an !== 8'hFF) begin
         // digit 3 of mask AA is lit here
         if (bus.o_an !== 8'hF7) begin
            errors++;
            $display("FAIL mid_pre cyc=%0d an=%h exp F7", cyc, bus.o_an);
         end
      end else begin
         errors++;
         $display("FAIL mid_pre cyc=%0d an=%h exp F7", cyc, bus.o_an);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      cyc = 0;
      while (cyc < 64) begin
         step();
         checks++;
         if ({bus.o_an, bus.o_seg} !== {8'hFF, 7'h7F}) begin
            errors++;
            $display("FAIL mid_blank cyc=%0d an=%h seg=%b exp FF/1111111", cyc, bus.o_an, bus.o_seg);
         end
         checks++;
         if (bus.o_frame_done !== (cyc % 32 == 0)) begin
            errors++;
            $display("FAIL mid_fd cyc=%0d fd=%b exp %b", cyc, bus.o_frame_done, (cyc % 32 == 0));
         end
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      cyc = 0;
      errors = 0;
      checks = 0;
      bus.i_en = 1'b1;
      bus.i_load = 1'b0;
      bus.i_data = 32'h0;
      bus.i_mask = 8'h00;
      test_reset();
      test_basic();
      test_tear_free();
      test_load_on_wrap();
      test_mask_enable();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
